axilite_chan_buf: RTL and testbench



---
 rtl/axilite_pkg.sv | 25 ++
 rtl/axilite_skid_stage.sv | 65 ++++++
 rtl/axilite_chan_buf.sv | 123 ++++++++++++
 tb/tb_axilite_chan_buf.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_pkg.sv
// Shared AXI-Lite definitions: channel buffer modes, response codes and
// per-channel payload widths used when instantiating axilite_chan_buf.
package axilite_pkg;

  typedef enum logic [1:0] {
    CHB_BYPASS = 2'd0,
    CHB_FWD    = 2'd1,
    CHB_SKID   = 2'd2,
    CHB_FIFO   = 2'd3
  } chb_mode_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  // Payload widths per channel: address, data+strobes, response, data+response.
  localparam int unsigned AW_PW = ADDR_WIDTH;
  localparam int unsigned W_PW  = DATA_WIDTH + DATA_WIDTH / 8;
  localparam int unsigned B_PW  = 2;
  localparam int unsigned AR_PW = ADDR_WIDTH;
  localparam int unsigned R_PW  = DATA_WIDTH + 2;

endpackage

// File: rtl/axilite_skid_stage.sv
// Two-entry registered skid buffer: both s_ready and m_valid come straight
// from flops, so there is no combinational path between the two sides.
module axilite_skid_stage
  import axilite_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PAYLOAD_WIDTH-1:0] s_payload,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [PAYLOAD_WIDTH-1:0] m_payload,
  output logic [1:0]               count
);

  logic                     main_vld;
  logic                     skid_vld;
  logic [PAYLOAD_WIDTH-1:0] main_data;
  logic [PAYLOAD_WIDTH-1:0] skid_data;
  logic                     push;
  logic                     pop;

  // Upstream is only stalled once the skid slot is occupied; clr masks both sides.
  assign s_ready   = !skid_vld && !clr;
  assign m_valid   = main_vld && !clr;
  assign m_payload = main_data;
  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  assign count     = {1'b0, main_vld} + {1'b0, skid_vld};

  // Main register refills from skid first to keep order, else from upstream;
  // skid only captures when main is held by backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
    end else if (clr) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
    end else if (!main_vld || pop) begin
      if (skid_vld) begin
        main_data <= skid_data;
        main_vld  <= 1'b1;
        skid_vld  <= 1'b0;
      end else if (push) begin
        main_data <= s_payload;
        main_vld  <= 1'b1;
      end else begin
        main_vld  <= 1'b0;
      end
    end else if (push) begin
      skid_data <= s_payload;
      skid_vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/axilite_chan_buf.sv
// Single AXI-Lite channel valid/ready buffer with selectable timing mode:
// pure wiring, one forward register, registered skid, or a DEPTH-entry FIFO.
module axilite_chan_buf
  import axilite_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH = 32,
  parameter chb_mode_e   MODE          = CHB_SKID,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PAYLOAD_WIDTH-1:0] s_payload,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [PAYLOAD_WIDTH-1:0] m_payload,
  output logic [CNT_W-1:0]         count
);

  generate
    if (MODE == CHB_BYPASS) begin : g_bypass
      // No state: clock, reset and flush have nothing to act on here.
      logic bypass_unused;
      assign bypass_unused = clk ^ rst_n ^ clr;
      assign m_valid   = s_valid;
      assign m_payload = s_payload;
      assign s_ready   = m_ready;
      assign count     = '0;

    end else if (MODE == CHB_FWD) begin : g_fwd
      logic                     vld;
      logic [PAYLOAD_WIDTH-1:0] data;
      logic                     push;

      // Ready passes through combinationally so a full stage still streams.
      assign s_ready   = (!vld || m_ready) && !clr;
      assign m_valid   = vld && !clr;
      assign m_payload = data;
      assign push      = s_valid && s_ready;
      assign count     = CNT_W'(vld);

      // Load on accepted input, empty when the held word is taken with no refill.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld  <= 1'b0;
          data <= '0;
        end else if (clr) begin
          vld  <= 1'b0;
          data <= '0;
        end else if (push) begin
          vld  <= 1'b1;
          data <= s_payload;
        end else if (m_ready) begin
          vld  <= 1'b0;
        end
      end

    end else if (MODE == CHB_SKID) begin : g_skid
      logic [1:0] skid_count;

      axilite_skid_stage #(
        .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
      ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_payload(s_payload),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_payload(m_payload),
        .count    (skid_count)
      );

      assign count = CNT_W'(skid_count);

    end else begin : g_fifo
      localparam int unsigned AW = $clog2(DEPTH);

      logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];
      logic [AW:0]              wr_ptr;
      logic [AW:0]              rd_ptr;
      logic                     full;
      logic                     empty;
      logic                     push;
      logic                     pop;

      // Extra wrap bit distinguishes full from empty when the indices match.
      assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      assign empty     = (wr_ptr == rd_ptr);
      assign s_ready   = !full && !clr;
      assign m_valid   = !empty && !clr;
      assign m_payload = mem[rd_ptr[AW-1:0]];
      assign push      = s_valid && s_ready;
      assign pop       = m_valid && m_ready;
      assign count     = CNT_W'(wr_ptr - rd_ptr);

      // Storage and pointers; a full buffer refuses writes even while popping.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
          if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_payload;
            wr_ptr              <= wr_ptr + 1'b1;
          end
          if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_axilite_chan_buf.sv
module tb_axilite_chan_buf;
  import axilite_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // SKID instance
  logic s_sv = 0, s_mr = 0, s_clr = 0;
  logic [31:0] s_pay = 0;
  logic s_sr, s_mv;
  logic [31:0] s_mp;
  logic [2:0] s_cnt;

  // FIFO instance
  logic f_sv = 0, f_mr = 0, f_clr = 0;
  logic [31:0] f_pay = 0;
  logic f_sr, f_mv;
  logic [31:0] f_mp;
  logic [2:0] f_cnt;

  // FWD instance
  logic w_sv = 0, w_mr = 0, w_clr = 0;
  logic [31:0] w_pay = 0;
  logic w_sr, w_mv;
  logic [31:0] w_mp;
  logic [2:0] w_cnt;

  // BYPASS instance
  logic b_sv = 0, b_mr = 0, b_clr = 0;
  logic [31:0] b_pay = 0;
  logic b_sr, b_mv;
  logic [31:0] b_mp;
  logic [2:0] b_cnt;

  axilite_chan_buf #(.PAYLOAD_WIDTH(32), .MODE(CHB_SKID), .DEPTH(4)) u_skid (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .s_valid(s_sv), .s_ready(s_sr),
    .s_payload(s_pay), .m_valid(s_mv), .m_ready(s_mr), .m_payload(s_mp), .count(s_cnt));

  axilite_chan_buf #(.PAYLOAD_WIDTH(32), .MODE(CHB_FIFO), .DEPTH(4)) u_fifo (
    .clk(clk), .rst_n(rst_n), .clr(f_clr), .s_valid(f_sv), .s_ready(f_sr),
    .s_payload(f_pay), .m_valid(f_mv), .m_ready(f_mr), .m_payload(f_mp), .count(f_cnt));

  axilite_chan_buf #(.PAYLOAD_WIDTH(32), .MODE(CHB_FWD), .DEPTH(4)) u_fwd (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .s_valid(w_sv), .s_ready(w_sr),
    .s_payload(w_pay), .m_valid(w_mv), .m_ready(w_mr), .m_payload(w_mp), .count(w_cnt));

  axilite_chan_buf #(.PAYLOAD_WIDTH(32), .MODE(CHB_BYPASS), .DEPTH(4)) u_byp (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .s_valid(b_sv), .s_ready(b_sr),
    .s_payload(b_pay), .m_valid(b_mv), .m_ready(b_mr), .m_payload(b_mp), .count(b_cnt));

  typedef struct {
    logic        sv;
    logic        mr;
    logic        clr;
    logic [31:0] pay;
    logic        e_sr;
    logic        e_mv;
    logic        chk_pay;
    logic [31:0] e_pay;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic sv, logic mr, logic clr, logic [31:0] pay,
                              logic e_sr, logic e_mv, logic chk_pay,
                              logic [31:0] e_pay, logic [2:0] e_cnt);
    vec_t v;
    v.sv = sv; v.mr = mr; v.clr = clr; v.pay = pay;
    v.e_sr = e_sr; v.e_mv = e_mv; v.chk_pay = chk_pay;
    v.e_pay = e_pay; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Outputs sampled before the edge that consumes the vector's inputs.
    //            sv  mr  clr pay    e_sr e_mv chkp e_pay  e_cnt
    tbl[0]  = mk(0, 1, 0, 32'h00, 1, 0, 1, 32'h00, 0);
    tbl[1]  = mk(1, 1, 0, 32'h11, 1, 0, 0, 32'h00, 0);
    tbl[2]  = mk(1, 1, 0, 32'h22, 1, 1, 1, 32'h11, 1);
    tbl[3]  = mk(1, 1, 0, 32'h33, 1, 1, 1, 32'h22, 1);
    tbl[4]  = mk(0, 1, 0, 32'h00, 1, 1, 1, 32'h33, 1);
    tbl[5]  = mk(0, 1, 0, 32'h00, 1, 0, 0, 32'h00, 0);
    tbl[6]  = mk(1, 1, 0, 32'h11, 1, 0, 0, 32'h00, 0);
    tbl[7]  = mk(1, 0, 0, 32'h22, 1, 1, 1, 32'h11, 1);
    tbl[8]  = mk(1, 0, 0, 32'h33, 0, 1, 1, 32'h11, 2);
    tbl[9]  = mk(1, 1, 0, 32'h33, 0, 1, 1, 32'h11, 2);
    tbl[10] = mk(1, 1, 0, 32'h33, 1, 1, 1, 32'h22, 1);
    tbl[11] = mk(0, 1, 0, 32'h00, 1, 1, 1, 32'h33, 1);
    tbl[12] = mk(0, 0, 0, 32'h00, 1, 0, 0, 32'h00, 0);
    tbl[13] = mk(1, 0, 0, 32'h44, 1, 0, 0, 32'h00, 0);
    tbl[14] = mk(1, 0, 1, 32'h45, 0, 0, 0, 32'h00, 1);
    tbl[15] = mk(0, 0, 0, 32'h00, 1, 0, 1, 32'h00, 0);

    // Reset state (rst_n low from time 0)
    #2;
    chk("rst.skid.s_ready", 32'(s_sr), 32'd1);
    chk("rst.skid.m_valid", 32'(s_mv), 32'd0);
    chk("rst.skid.m_payload", s_mp, 32'h0);
    chk("rst.fifo.s_ready", 32'(f_sr), 32'd1);
    chk("rst.fifo.count", 32'(f_cnt), 32'd0);
    chk("rst.fwd.m_valid", 32'(w_mv), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // SKID table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_sv = tbl[i].sv; s_mr = tbl[i].mr; s_clr = tbl[i].clr; s_pay = tbl[i].pay;
      #1;
      chk($sformatf("skid[%0d].s_ready", i), 32'(s_sr), 32'(tbl[i].e_sr));
      chk($sformatf("skid[%0d].m_valid", i), 32'(s_mv), 32'(tbl[i].e_mv));
      chk($sformatf("skid[%0d].count", i), 32'(s_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].chk_pay)
        chk($sformatf("skid[%0d].m_payload", i), s_mp, tbl[i].e_pay);
    end

    // FIFO fill: 5 offers with m_ready=0, fifth must be refused
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      f_sv = 1; f_mr = 0; f_pay = 32'hA0 + 32'(i);
      #1;
      chk($sformatf("fifo.fill%0d.s_ready", i), 32'(f_sr), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("fifo.fill%0d.count", i), 32'(f_cnt), 32'(i < 4 ? i : 4));
    end
    chk("fifo.full.m_payload", f_mp, 32'hA0);
    // Full with simultaneous pop: no push this cycle
    @(negedge clk);
    f_mr = 1;
    #1;
    chk("fifo.fullpop.s_ready", 32'(f_sr), 32'd0);
    chk("fifo.fullpop.m_payload", f_mp, 32'hA0);
    @(negedge clk); #1;
    chk("fifo.afterpop.count", 32'(f_cnt), 32'd3);
    chk("fifo.afterpop.s_ready", 32'(f_sr), 32'd1);
    chk("fifo.afterpop.m_payload", f_mp, 32'hA1);
    @(negedge clk);
    f_sv = 0;
    #1;
    chk("fifo.drain.A2", f_mp, 32'hA2);
    chk("fifo.drain.cnt3", 32'(f_cnt), 32'd3);
    @(negedge clk); #1;
    chk("fifo.drain.A3", f_mp, 32'hA3);
    @(negedge clk); #1;
    chk("fifo.drain.A4", f_mp, 32'hA4);
    chk("fifo.drain.cnt1", 32'(f_cnt), 32'd1);
    @(negedge clk); #1;
    chk("fifo.drain.empty", 32'(f_mv), 32'd0);
    chk("fifo.drain.cnt0", 32'(f_cnt), 32'd0);

    // Streaming push/pop across the pointer wrap
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      f_sv = (i < 10); f_mr = 1; f_pay = 32'hB0 + 32'(i);
      #1;
      if (i == 0) begin
        chk("fifo.wrap0.m_valid", 32'(f_mv), 32'd0);
      end else begin
        chk($sformatf("fifo.wrap%0d.m_valid", i), 32'(f_mv), 32'd1);
        chk($sformatf("fifo.wrap%0d.m_payload", i), f_mp, 32'hB0 + 32'(i - 1));
        chk($sformatf("fifo.wrap%0d.count", i), 32'(f_cnt), 32'd1);
      end
    end
    f_sv = 0;

    // Flush with three entries held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      f_sv = 1; f_mr = 0; f_pay = 32'hC0 + 32'(i);
    end
    @(negedge clk);
    f_sv = 1; f_pay = 32'h99; f_clr = 1;
    #1;
    chk("fifo.clr.s_ready", 32'(f_sr), 32'd0);
    chk("fifo.clr.m_valid", 32'(f_mv), 32'd0);
    chk("fifo.clr.count", 32'(f_cnt), 32'd3);
    @(negedge clk);
    f_clr = 0; f_sv = 1; f_pay = 32'h55;
    #1;
    chk("fifo.postclr.count", 32'(f_cnt), 32'd0);
    chk("fifo.postclr.m_valid", 32'(f_mv), 32'd0);
    chk("fifo.postclr.s_ready", 32'(f_sr), 32'd1);
    @(negedge clk);
    f_sv = 0;
    #1;
    chk("fifo.post55.m_valid", 32'(f_mv), 32'd1);
    chk("fifo.post55.m_payload", f_mp, 32'h55);
    chk("fifo.post55.count", 32'(f_cnt), 32'd1);

    // FWD: ready follows m_ready combinationally while full
    @(negedge clk);
    w_sv = 1; w_mr = 0; w_pay = 32'h66;
    #1;
    chk("fwd.empty.s_ready", 32'(w_sr), 32'd1);
    @(negedge clk);
    w_sv = 0;
    #1;
    chk("fwd.full.m_valid", 32'(w_mv), 32'd1);
    chk("fwd.full.m_payload", w_mp, 32'h66);
    chk("fwd.full.s_ready", 32'(w_sr), 32'd0);
    chk("fwd.full.count", 32'(w_cnt), 32'd1);
    w_mr = 1;
    #1;
    chk("fwd.comb.s_ready", 32'(w_sr), 32'd1);

    // Load skid to capacity before the asynchronous reset
    @(negedge clk);
    s_sv = 1; s_mr = 0; s_pay = 32'h77;
    @(negedge clk);
    s_pay = 32'h78;
    @(negedge clk);
    s_sv = 0;
    #1;
    chk("skid.preload.count", 32'(s_cnt), 32'd2);

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.skid.m_valid", 32'(s_mv), 32'd0);
    chk("arst.skid.count", 32'(s_cnt), 32'd0);
    chk("arst.skid.s_ready", 32'(s_sr), 32'd1);
    chk("arst.skid.m_payload", s_mp, 32'h0);
    chk("arst.fifo.m_valid", 32'(f_mv), 32'd0);
    chk("arst.fifo.count", 32'(f_cnt), 32'd0);
    chk("arst.fwd.m_valid", 32'(w_mv), 32'd0);

    // BYPASS tracks inputs in the same cycle, reset or not
    b_sv = 1; b_mr = 0; b_pay = 32'h99; b_clr = 1;
    #1;
    chk("byp.m_valid1", 32'(b_mv), 32'd1);
    chk("byp.m_payload", b_mp, 32'h99);
    chk("byp.s_ready0", 32'(b_sr), 32'd0);
    chk("byp.count", 32'(b_cnt), 32'd0);
    b_sv = 0; b_mr = 1;
    #1;
    chk("byp.m_valid0", 32'(b_mv), 32'd0);
    chk("byp.s_ready1", 32'(b_sr), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
